// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter for the shared single-port sort memory, with lock-based bursts.
// Optional access statistics are enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic          wren0,
  input  logic          wren1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wren,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_q,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_reg, state_next;
  logic          last_reg, last_next;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic          rvalid0_reg, rvalid1_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      last_reg    <= 1'b1;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rvalid0_reg <= 1'b0;
      rvalid1_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      rvalid0_reg <= gnt0 & ~wren0;
      rvalid1_reg <= gnt1 & ~wren1;
      if (gnt0 || gnt1) begin
        addr_reg  <= mem_addr;
        wdata_reg <= mem_wdata;
      end
    end
  end

  // An owner that drops its request releases immediately, so the other port can take this cycle.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_next = IDLE;
    last_next  = last_reg;
    unique case (state_reg)
      OWN0: begin
        if (req0) gnt0 = 1'b1;
        else      gnt1 = req1;
      end
      OWN1: begin
        if (req1) gnt1 = 1'b1;
        else      gnt0 = req0;
      end
      default: begin
        if (req0 && req1) begin
          gnt0 = last_reg;
          gnt1 = ~last_reg;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
    endcase
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
    if (gnt0) begin
      state_next = lock0 ? OWN0 : IDLE;
      last_next  = 1'b0;
    end else if (gnt1) begin
      state_next = lock1 ? OWN1 : IDLE;
      last_next  = 1'b1;
    end
  end

  always_comb begin
    mem_addr  = addr_reg;
    mem_wdata = wdata_reg;
    mem_wren  = 1'b0;
    if (gnt0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
      mem_wren  = wren0;
    end else if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_wren  = wren1;
    end
  end

  assign rvalid0 = rvalid0_reg;
  assign rvalid1 = rvalid1_reg;
  assign rdata0  = mem_q;
  assign rdata1  = mem_q;

`ifdef MEM_ARB_STATS_EN
  logic [CW-1:0] cnt0_reg, cnt1_reg;

  // Saturating counters; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_reg <= '0;
      cnt1_reg <= '0;
    end else begin
      if (gnt0 && cnt0_reg != '1) cnt0_reg <= cnt0_reg + CW'(1);
      if (gnt1 && cnt1_reg != '1) cnt1_reg <= cnt1_reg + CW'(1);
    end
  end

  assign cnt0 = cnt0_reg;
  assign cnt1 = cnt1_reg;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a behavioural 256x8 memory
// (registered read, init pattern addr^0xC3).
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, lock0, lock1, wren0, wren1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_wren;
  logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_q;
  logic [3:0] cnt0, cnt1;

  int checks = 0;
  int failures = 0;

`ifdef MEM_ARB_STATS_EN
  localparam logic [3:0] EXP_CNT0 = 4'd15;
`else
  localparam logic [3:0] EXP_CNT0 = 4'd0;
`endif

  mem_arbiter #(.AW(8), .DW(8), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wren0(wren0), .wren1(wren1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_q(mem_q),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  logic [7:0] mem_model [256];
  bit         init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem_model[i] <= 8'(i) ^ 8'hC3;
      init_done <= 1'b1;
    end else begin
      if (mem_wren) mem_model[mem_addr] <= mem_wdata;
      mem_q <= mem_model[mem_addr];
    end
  end

  typedef struct {
    logic       req0, lock0, wren0;
    logic [7:0] addr0, wdata0;
    logic       req1, lock1, wren1;
    logic [7:0] addr1, wdata1;
    logic       g0, g1, rv0, rv1;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(logic r0, logic l0, logic w0, logic [7:0] a0, logic [7:0] d0,
                              logic r1, logic l1, logic w1, logic [7:0] a1, logic [7:0] d1,
                              logic g0, logic g1, logic rv0, logic rv1, logic [7:0] rd);
    vec_t v;
    v.req0 = r0; v.lock0 = l0; v.wren0 = w0; v.addr0 = a0; v.wdata0 = d0;
    v.req1 = r1; v.lock1 = l1; v.wren1 = w1; v.addr1 = a1; v.wdata1 = d1;
    v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rv1 = rv1; v.rdata = rd;
    return v;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(vec_t v);
    req0 = v.req0; lock0 = v.lock0; wren0 = v.wren0; addr0 = v.addr0; wdata0 = v.wdata0;
    req1 = v.req1; lock1 = v.lock1; wren1 = v.wren1; addr1 = v.addr1; wdata1 = v.wdata1;
  endtask

  initial begin
    // Alternating tie-break reads of 0x00/0x01 (mem init: 0xC3, 0xC2)
    vecs[0]  = mk(1,0,0,8'h00,8'h00, 1,0,0,8'h01,8'h00, 1,0,0,0,8'h00);
    vecs[1]  = mk(1,0,0,8'h00,8'h00, 1,0,0,8'h01,8'h00, 0,1,1,0,8'hC3);
    vecs[2]  = mk(1,0,0,8'h00,8'h00, 1,0,0,8'h01,8'h00, 1,0,0,1,8'hC2);
    vecs[3]  = mk(1,0,0,8'h00,8'h00, 1,0,0,8'h01,8'h00, 0,1,1,0,8'hC3);
    vecs[4]  = mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,1,8'hC2);
    // Port 0 alone: write 0xA5 to 0x10, read it back
    vecs[5]  = mk(1,0,1,8'h10,8'hA5, 0,0,0,8'h00,8'h00, 1,0,0,0,8'h00);
    vecs[6]  = mk(1,0,0,8'h10,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,0,8'h00);
    vecs[7]  = mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,1,0,8'hA5);
    // Port 1 locked burst 0x20..0x23 while port 0 waits on 0x30
    vecs[8]  = mk(1,0,0,8'h30,8'h00, 1,1,0,8'h20,8'h00, 0,1,0,0,8'h00);
    vecs[9]  = mk(1,0,0,8'h30,8'h00, 1,1,0,8'h21,8'h00, 0,1,0,1,8'hE3);
    vecs[10] = mk(1,0,0,8'h30,8'h00, 1,1,0,8'h22,8'h00, 0,1,0,1,8'hE2);
    vecs[11] = mk(1,0,0,8'h30,8'h00, 1,1,0,8'h23,8'h00, 0,1,0,1,8'hE1);
    vecs[12] = mk(1,0,0,8'h30,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,1,8'hE0);
    vecs[13] = mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,1,0,8'hF3);
    // Locked write then locked read by port 0 blocks port 1 until release
    vecs[14] = mk(1,1,1,8'h40,8'h5A, 0,0,0,8'h41,8'h00, 1,0,0,0,8'h00);
    vecs[15] = mk(1,1,0,8'h40,8'h00, 1,0,0,8'h41,8'h00, 1,0,0,0,8'h00);
    vecs[16] = mk(0,0,0,8'h00,8'h00, 1,0,0,8'h41,8'h00, 0,1,1,0,8'h5A);
    vecs[17] = mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,1,8'h82);

    rst_n = 1'b0;
    drive(mk(1,0,1,8'h77,8'h66, 1,0,0,8'h55,8'h00, 0,0,0,0,8'h00));
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt0", {7'd0, gnt0}, 8'd0);
    check("rst_gnt1", {7'd0, gnt1}, 8'd0);
    check("rst_rvalid0", {7'd0, rvalid0}, 8'd0);
    check("rst_rvalid1", {7'd0, rvalid1}, 8'd0);
    check("rst_mem_wren", {7'd0, mem_wren}, 8'd0);
    check("rst_mem_addr", mem_addr, 8'd0);
    check("rst_mem_wdata", mem_wdata, 8'd0);
    check("rst_cnt0", {4'd0, cnt0}, 8'd0);
    @(negedge clk);
    drive(mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,8'h00));
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_gnt0", i), {7'd0, gnt0}, {7'd0, vecs[i].g0});
      check($sformatf("v%0d_gnt1", i), {7'd0, gnt1}, {7'd0, vecs[i].g1});
      check($sformatf("v%0d_rvalid0", i), {7'd0, rvalid0}, {7'd0, vecs[i].rv0});
      check($sformatf("v%0d_rvalid1", i), {7'd0, rvalid1}, {7'd0, vecs[i].rv1});
      if (vecs[i].rv0) check($sformatf("v%0d_rdata0", i), rdata0, vecs[i].rdata);
      if (vecs[i].rv1) check($sformatf("v%0d_rdata1", i), rdata1, vecs[i].rdata);
      $display("vec %0d: gnt0=%0b gnt1=%0b rvalid0=%0b rvalid1=%0b rdata=%0h",
               i, gnt0, gnt1, rvalid0, rvalid1, rdata0);
    end

    // Idle cycle: memory bus keeps last granted address, no write strobe
    #1;
    check("hold_mem_addr", mem_addr, 8'h41);
    check("hold_mem_wren", {7'd0, mem_wren}, 8'd0);

    // Reset the cycle after an accepted locked read
    @(negedge clk);
    drive(mk(1,1,0,8'h05,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,8'h00));
    #1;
    check("mid_gnt0", {7'd0, gnt0}, 8'd1);
    @(posedge clk);
    #1;
    check("mid_rvalid0_pre", {7'd0, rvalid0}, 8'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid0", {7'd0, rvalid0}, 8'd0);
    check("mid_rst_gnt0", {7'd0, gnt0}, 8'd0);
    check("mid_rst_mem_wren", {7'd0, mem_wren}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(1,0,0,8'h05,8'h00, 1,0,0,8'h06,8'h00, 0,0,0,0,8'h00));
    #1;
    check("post_rst_tie_gnt0", {7'd0, gnt0}, 8'd1);
    check("post_rst_tie_gnt1", {7'd0, gnt1}, 8'd0);
    $display("reset mid-burst: tie after reset gnt0=%0b gnt1=%0b", gnt0, gnt1);
    @(negedge clk);
    drive(mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,8'h00));
    #1;
    check("post_rst_rvalid0", {7'd0, rvalid0}, 8'd1);
    check("post_rst_rdata0", rdata0, 8'hC6);

    // Statistics: 20 port-0 writes after a clean reset
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("stats_rst_cnt0", {4'd0, cnt0}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive(mk(1,0,1,8'h50,8'(k), 0,0,0,8'h00,8'h00, 0,0,0,0,8'h00));
      @(negedge clk);
    end
    drive(mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,8'h00));
    #1;
    check("stats_cnt0", {4'd0, cnt0}, {4'd0, EXP_CNT0});
    check("stats_cnt1", {4'd0, cnt1}, 8'd0);
    $display("stats: cnt0=%0d cnt1=%0d", cnt0, cnt1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port 256x8 sort memory between the sort engine (port 0) and a host/loader-display requester (port 1). It sits between the requesters and the `mem` instance and owns `mem`'s address, write-enable and write-data inputs. It grants at most one access per cycle, using round-robin with optional lock for bursts. It returns read data with the memory's one-cycle latency, tagged to the issuing port.

## Interface
- AW, 8, address width (memory depth 2^AW)
- DW, 8, data width
- CW, 16, statistics counter width (used only with MEM_ARB_STATS_EN)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, held until granted
- lock0 / lock1  in  1  keep ownership after this access
- addr0 / addr1  in  AW  access address
- wren0 / wren1  in  1  1 = write, 0 = read
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  access accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid for this port (registered)
- rdata0 / rdata1  out  DW  read data, meaningful only when the matching rvalid is high
- mem_addr  out  AW  to mem.address
- mem_wren  out  1  to mem.wren
- mem_wdata  out  DW  to mem.data
- mem_q  in  DW  from mem.q
- cnt0 / cnt1  out  CW  accepted-access counts (statistics)

## Operation
- Accepted access: reqN && gntN. At most one of gnt0/gnt1 is high in any cycle.
- FSM states:
  - IDLE: no owner.
  - OWN0: port 0 holds the memory.
  - OWN1: port 1 holds the memory.
- IDLE arbitration:
  - Only one port requests: that port wins.
  - Both request: the port that did not win last wins.
  - Pointer `last` resets to 1, so port 0 wins the first tie.
- Transition: on an accepted access with lockN=1, go to OWNn; with lockN=0, go to IDLE. `last` updates on every accepted access.
- OWNn with reqN=1: only port N is granted.
- OWNn with reqN=0: ownership is released that same cycle. Arbitration is IDLE-style with port N absent, so the other port can be granted immediately.
- Memory drive:
  - Granted cycle: mem_addr, mem_wren and mem_wdata come from the granted port.
  - No grant: mem_wren=0, and mem_addr/mem_wdata hold the last granted values (registered copies).
- Read return: an accepted read sets rvalidN=1 on the next cycle, for exactly one cycle. rdataN = mem_q on both ports; consumers qualify it with rvalid.
- Writes produce no rvalid.
- Back-to-back reads from one port return one rvalid per cycle, in order.

## Timing
- Grant latency: 0 cycles, since gnt is combinational from req, lock and state.
- Read latency: 1 cycle, from the accepted edge to rvalid high.
- Write: committed at the rising edge ending the granted cycle.
- Requesters must hold addr, wren and wdata stable while reqN=1 and gntN=0.
- Throughput: one access per cycle, no bubbles on a grant handover.
- Reset values (async, rst_n low):
  - state=IDLE, last=1
  - rvalid0/1=0, gnt0/1=0 (gated by rst_n)
  - mem_wren=0, mem_addr=0, mem_wdata=0
  - cnt0/1=0
- Reset during a pending read: rvalid is cleared and the read result is discarded.
- Lock with a write: ownership behaves the same as for reads.
- Requesting port changes lock while not granted: no effect.

## Configuration
- MEM_ARB_STATS_EN defined:
  - cnt0 and cnt1 each increment by 1 per accepted access on their port.
  - Counters saturate at 2^CW-1 and are cleared only by reset.
- MEM_ARB_STATS_EN undefined: counter logic is removed and cnt0/cnt1 are tied to 0. Ports remain present.

## Test plan
- Port 0 only: write 0xA5 to 0x10, then read 0x10 → gnt0 in both cycles; rvalid0=1 one cycle after the read with rdata0=0xA5; rvalid1 stays 0.
- Both ports continuously reading 0x00 and 0x01, no lock → grants alternate 0,1,0,1 starting with port 0; each rvalid follows its own grant by one cycle.
- Port 1 locks for a 4-read burst (addresses 0x20–0x23) while port 0 requests throughout → gnt1 for 4 consecutive cycles; gnt0 is granted the cycle port 1 drops req.
- Owner drops req while the other port requests in the same cycle → the other port is granted that cycle with no idle cycle.
- rst_n pulsed low mid-burst, the cycle after an accepted read → rvalid0/1=0, mem_wren=0, state IDLE; the first tie after reset goes to port 0.
- With MEM_ARB_STATS_EN and CW=4: 20 port-0 accesses → cnt0=15 (saturated), cnt1=0. Without the macro: cnt0=cnt1=0.
